// File: rtl/mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op codes, FSM states
// and default latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit owning architectural HI/LO.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU; otherwise they are no-ops.
import mdu_pkg::*;

module ex_mdu #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      sh_hi_q, sh_hi_d;
    logic [31:0]      sh_lo_q, sh_lo_d;
    logic             sh_wr_q, sh_wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    mdu_op_e            op_e;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    // Returns {remainder, quotient}; remainder takes the dividend's sign.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = sa;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign op_e   = mdu_op_e'(op);
    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_wr_d = sh_wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !req) begin
                    case (op_e)
                        MULT: begin
                            {sh_hi_d, sh_lo_d} = prod_s;
                            sh_wr_d = 1'b1;
                            count_d = CNT_W'(MUL_LAT);
                            state_d = RUN;
                        end
                        MULTU: begin
                            {sh_hi_d, sh_lo_d} = prod_u;
                            sh_wr_d = 1'b1;
                            count_d = CNT_W'(MUL_LAT);
                            state_d = RUN;
                        end
                        DIV: begin
                            {sh_hi_d, sh_lo_d} = div_signed(rs, rt);
                            sh_wr_d = (rt != 32'd0);
                            count_d = CNT_W'(DIV_LAT);
                            state_d = RUN;
                        end
                        DIVU: begin
                            {sh_hi_d, sh_lo_d} = div_unsigned(rs, rt);
                            sh_wr_d = (rt != 32'd0);
                            count_d = CNT_W'(DIV_LAT);
                            state_d = RUN;
                        end
                        MTHI: hi_d = rs;
                        MTLO: lo_d = rs;
`ifdef MDU_MADD_EN
                        MADD: begin
                            {sh_hi_d, sh_lo_d} = {hi_q, lo_q} + prod_s;
                            sh_wr_d = 1'b1;
                            count_d = CNT_W'(MUL_LAT);
                            state_d = RUN;
                        end
                        MADDU: begin
                            {sh_hi_d, sh_lo_d} = {hi_q, lo_q} + prod_u;
                            sh_wr_d = 1'b1;
                            count_d = CNT_W'(MUL_LAT);
                            state_d = RUN;
                        end
                        MSUB: begin
                            {sh_hi_d, sh_lo_d} = {hi_q, lo_q} - prod_s;
                            sh_wr_d = 1'b1;
                            count_d = CNT_W'(MUL_LAT);
                            state_d = RUN;
                        end
                        MSUBU: begin
                            {sh_hi_d, sh_lo_d} = {hi_q, lo_q} - prod_u;
                            sh_wr_d = 1'b1;
                            count_d = CNT_W'(MUL_LAT);
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // A start while running is never issued by the hazard unit and is ignored.
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (sh_wr_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_wr_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_wr_q <= sh_wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu: mult/div latency and results,
// HI/LO moves, req squashing, divide by zero, reset abort, optional MADD ops.
import mdu_pkg::*;

module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    ex_mdu dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(start && busy)) else $error("hazard: start issued while busy");
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One-cycle request, returns #1 after the issuing edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic r);
        op = o; rs = a; rt = b; req = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0; op = 4'd0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        logic [31:0] pre_hi;
        logic [31:0] hold_hi;
        pre_hi  = hi;
        hold_hi = hi;
        issue(o, a, b, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            hold_hi = hi;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"},  64'(n), 64'(lat));
        chk({tag, "_hold"}, 64'(hold_hi), 64'(pre_hi));
        chk({tag, "_hi"},   64'(hi), 64'(ehi));
        chk({tag, "_lo"},   64'(lo), 64'(elo));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; req = 1'b0; start = 1'b0; op = 4'd0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mult",  MULT,  32'hFFFF_FFFF, 32'd2, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  DIVU,  32'd7,         32'd2, 10, 32'd1,         32'd3);
        run_op("divov", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        issue(MTHI, 32'h1234, 32'd0, 1'b1);
        chk("mthi_req_hi",   64'(hi),   64'd0);
        chk("mthi_req_busy", 64'(busy), 64'd0);
        issue(MTHI, 32'h1234, 32'd0, 1'b0);
        chk("mthi_hi",   64'(hi),   64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);

        issue(DIV, 32'd9, 32'd3, 1'b1);
        chk("div_req_busy", 64'(busy), 64'd0);

        issue(MTHI, 32'hA, 32'd0, 1'b0);
        issue(MTLO, 32'hB, 32'd0, 1'b0);
        chk("mtlo_lo", 64'(lo), 64'hB);
        run_op("div0", DIV, 32'd100, 32'd0, 10, 32'hA, 32'hB);

        // req pulsed on the second RUN cycle must not disturb the in-flight mult
        issue(MULT, 32'd3, 32'd5, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            req = (n == 1);
            @(posedge clk); #1;
            n++;
        end
        req = 1'b0;
        chk("mreq_lat", 64'(n),  64'd5);
        chk("mreq_hi",  64'(hi), 64'd0);
        chk("mreq_lo",  64'(lo), 64'd15);

        issue(MULT, 32'd7, 32'd9, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        chk("mrst_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_hi",   64'(hi),   64'd0);
        chk("mrst_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("mrst_late_lo",   64'(lo),   64'd0);
        chk("mrst_late_busy", 64'(busy), 64'd0);

        issue(MTLO, 32'd5, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
        run_op("madd",  MADD,  32'd3, 32'd4,  5, 32'd0,         32'd17);
        run_op("msubu", MSUBU, 32'd1, 32'd20, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        issue(MADD, 32'd3, 32'd4, 1'b0);
        chk("madd_off_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("madd_off_lo", 64'(lo), 64'd5);
        chk("madd_off_hi", 64'(hi), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded op plus rs/rt operands latched into EX; owns the architectural HI/LO registers.
- Exports busy so the hazard unit can stall subsequent mult/div/mfhi/mflo/mthi/mtlo in ID.
- Honours the exception/interrupt request so an instruction being cancelled in EX never starts or writes HI/LO.

Parameters:
- MUL_LAT, 5, cycles busy is held for mult/multu (and madd family).
- DIV_LAT, 10, cycles busy is held for div/divu.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  exception/interrupt request; the instruction in EX is being flushed this cycle.
- start  in  1  EX instruction is a valid MDU op this cycle (decoded from instrE).
- op  in  4  MDU operation code (package enum).
- rs  in  32  forwarded rs operand in EX.
- rt  in  32  forwarded rt operand in EX.
- busy  out  1  operation in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset: state IDLE, count=0, busy=0, hi=0, lo=0, shadow result regs=0. Reset mid-operation aborts it and leaves HI/LO zero.
- States: IDLE and RUN. busy = (state==RUN), registered.
- Start rule: when start=1 && req=0 && state==IDLE, the following apply.
  - MULT/MULTU: compute the 64-bit signed/unsigned product into shadow {hi,lo}, load count=MUL_LAT, go to RUN.
  - DIV/DIVU: compute signed/unsigned quotient into shadow lo and remainder into shadow hi, load count=DIV_LAT, go to RUN. The remainder sign follows the dividend (C truncation).
  - MTHI/MTLO: write rs into hi/lo at that edge, with no busy.
- RUN: count decrements each edge. On the edge where count goes 1->0, copy shadow to hi/lo and return to IDLE. busy is therefore high for exactly N cycles after the start edge, and hi/lo change on the same edge busy falls.
- Divide by zero (rt==0): the unit still goes busy for DIV_LAT. On completion HI/LO stay unchanged (shadow write suppressed).
- Signed overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- req=1 with start=1: the op is ignored entirely. No state change, and MTHI/MTLO do not write.
- req=1 during RUN: the in-flight op continues and completes, because its instruction already retired past EX.
- start=1 while RUN: ignored. The hazard unit guarantees this never occurs; the bench asserts it.
- Hazard unit stall condition is (start|busy) with an MDU-reading op in ID. This is not computed here.

Optional Feature:
- MDU_MADD_EN defined: ops MADD/MADDU/MSUB/MSUBU are accepted. Shadow = {hi,lo} ± 64-bit product (signed/unsigned), latency MUL_LAT.
- Not defined: those codes are treated as no-op (no busy, no write).

Decomposition:
- Shared package mdu_pkg holds:
  - op enum: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10;
  - state enum IDLE/RUN;
  - default latencies.
- Opcode-to-op decode lives in the EX control decoder, not here.
- No sub-module: arithmetic is behavioural operators inside ex_mdu.

Test Plan:
- Reset then mult rs=0xFFFFFFFF rt=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=-7 (0xFFFFFFF9) rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=2 -> lo=3, hi=1.
- mthi rs=0x1234 with req=1 -> hi unchanged; same op with req=0 -> hi=0x1234 next edge, busy stays 0.
- div rt=0 after hi=0xA, lo=0xB -> busy 10 cycles, then hi=0xA, lo=0xB.
- mult started, req pulsed on cycle 2 of RUN -> still completes with the correct product; reset asserted on cycle 3 of a second mult -> busy=0, hi=lo=0 next edge.
- (MDU_MADD_EN) hi=0, lo=5, then madd rs=3 rt=4 -> after 5 cycles lo=17, hi=0; msubu rs=1 rt=20 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
